pipe_hazard_ctrl: RTL and testbench

Hazard and stall controller for the five-stage pipeline. It sequences the IF/ID and ID/EX stage registers and the PC by:
- detecting load-use and RAW hazards;
- tracking the multi-cycle multiply/divide unit (MDU);
- flushing wrong-path instructions on a taken branch.

It sits beside the decode stage and drives the write-enable and flush inputs of the PC, IF/ID and ID/EX registers.

---
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: load-use, RAW, MDU busy tracking and branch flush.
// Define PIPE_FWD_EN when the EX/MEM->EX forwarding network is present.
module pipe_hazard_ctrl #(
    parameter int MDU_LATENCY = 32
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        ID_MduStart,
    input  logic        ID_MduRead,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_WriteReg,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_WriteReg,
    input  logic        EX_BranchTaken,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        MduBusy,
    output logic [15:0] Stall_Cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] LAT = 8'(MDU_LATENCY);

    state_t      r_state;
    logic [7:0]  r_mdu_cnt;
    logic [15:0] r_stall_cnt;

    logic       w_ex_match;
    logic       w_mem_match;
    logic       w_load_use;
    logic       w_mdu_busy;
    logic       w_mdu_haz;
    logic       w_data_haz;
    logic       w_stall;
    logic       w_mdu_accept;
    logic [7:0] w_cnt_next;

    assign w_ex_match  = (EX_WriteReg != 5'd0) &&
                         ((EX_WriteReg == ID_Rs) ||
                          (ID_UsesRt && (EX_WriteReg == ID_Rt)));
    assign w_mem_match = (MEM_WriteReg != 5'd0) &&
                         ((MEM_WriteReg == ID_Rs) ||
                          (ID_UsesRt && (MEM_WriteReg == ID_Rt)));

    assign w_load_use = EX_MemRead && w_ex_match;
    assign w_mdu_busy = (r_mdu_cnt != 8'd0);
    assign w_mdu_haz  = (ID_MduStart || ID_MduRead) && w_mdu_busy;

`ifdef PIPE_FWD_EN
    logic w_unused;
    assign w_unused   = &{1'b0, EX_RegWrite, MEM_RegWrite, w_mem_match};
    assign w_data_haz = 1'b0;
`else
    // RF writes in the first half-cycle, so WB never needs a stall
    assign w_data_haz = (EX_RegWrite && w_ex_match) ||
                        (MEM_RegWrite && w_mem_match);
`endif

    assign w_stall      = w_load_use || w_mdu_haz || w_data_haz;
    assign w_mdu_accept = ID_MduStart && !w_stall && !EX_BranchTaken;

    always_comb begin
        w_cnt_next = r_mdu_cnt;
        if (w_mdu_accept) begin
            w_cnt_next = LAT;
        end else if (w_mdu_busy) begin
            w_cnt_next = r_mdu_cnt - 8'd1;
        end
    end

    always_comb begin
        PCWrite    = 1'b1;
        IFID_Write = 1'b1;
        IFID_Flush = 1'b0;
        IDEX_Flush = 1'b0;
        if (Rst) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (EX_BranchTaken) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (w_stall) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
        end
    end

    assign MduBusy   = w_mdu_busy && !Rst;
    assign Stall_Cnt = r_stall_cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= RUN;
            r_mdu_cnt   <= 8'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_mdu_cnt <= w_cnt_next;
            if (w_stall && !EX_BranchTaken && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (EX_BranchTaken) begin
                r_state <= RUN;
            end else begin
                unique case (r_state)
                    RUN: begin
                        if (w_mdu_haz) begin
                            r_state <= MDU_WAIT;
                        end else if (w_load_use) begin
                            r_state <= LU_STALL;
                        end
                    end
                    LU_STALL: r_state <= RUN;
                    MDU_WAIT: begin
                        if (w_cnt_next == 8'd0) begin
                            r_state <= RUN;
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MDU_LATENCY = 4.
module tb_pipe_hazard_ctrl;

    localparam logic [3:0] RUN_O = 4'b1100;
    localparam logic [3:0] STL_O = 4'b0001;
    localparam logic [3:0] BR_O  = 4'b1111;
    localparam logic [3:0] RST_O = 4'b0011;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
    logic        ID_UsesRt, ID_MduStart, ID_MduRead;
    logic        EX_RegWrite, EX_MemRead, MEM_RegWrite, EX_BranchTaken;
    logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, MduBusy;
    logic [15:0] Stall_Cnt;

    int n_pass = 0;
    int n_total = 0;
    int exp_sc = 0;

    wire [3:0] ctl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush};

    pipe_hazard_ctrl #(.MDU_LATENCY(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_MduStart(ID_MduStart), .ID_MduRead(ID_MduRead),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_WriteReg(EX_WriteReg), .MEM_RegWrite(MEM_RegWrite),
        .MEM_WriteReg(MEM_WriteReg), .EX_BranchTaken(EX_BranchTaken),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .MduBusy(MduBusy), .Stall_Cnt(Stall_Cnt)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
        ID_MduStart = 1'b0; ID_MduRead = 1'b0;
        EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
        MEM_RegWrite = 1'b0; MEM_WriteReg = 5'd0; EX_BranchTaken = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        idle();
        #2;
        n_total++;
        if (ctl !== RST_O) $display("FAIL reset_ctl got=%b exp=%b", ctl, RST_O);
        else n_pass++;
        n_total++;
        if (MduBusy !== 1'b0 || Stall_Cnt !== 16'd0)
            $display("FAIL reset_state busy=%b cnt=%0d exp 0/0", MduBusy, Stall_Cnt);
        else n_pass++;
        tick();
        tick();
        Rst = 1'b0;
        #1;
        n_total++;
        if (ctl !== RUN_O) $display("FAIL reset_release got=%b exp=%b", ctl, RUN_O);
        else n_pass++;
    endtask

    task automatic test_load_use();
        idle();
        EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        #1;
        n_total++;
        if (ctl !== STL_O) $display("FAIL lu_rs got=%b exp=%b", ctl, STL_O);
        else n_pass++;
        tick();
        exp_sc++;
        idle();
        #1;
        n_total++;
        if (ctl !== RUN_O || Stall_Cnt !== 16'(exp_sc))
            $display("FAIL lu_after ctl=%b cnt=%0d exp=%b/%0d", ctl, Stall_Cnt, RUN_O, exp_sc);
        else n_pass++;
        EX_MemRead = 1'b1; EX_WriteReg = 5'd9; ID_Rs = 5'd3; ID_Rt = 5'd9;
        #1;
        n_total++;
        if (ctl !== RUN_O) $display("FAIL lu_rt_unused got=%b exp=%b", ctl, RUN_O);
        else n_pass++;
        ID_UsesRt = 1'b1;
        #1;
        n_total++;
        if (ctl !== STL_O) $display("FAIL lu_rt got=%b exp=%b", ctl, STL_O);
        else n_pass++;
        tick();
        exp_sc++;
        idle();
        #1;
    endtask

    task automatic test_reg_zero();
        idle();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd0; ID_Rs = 5'd0;
        #1;
        n_total++;
        if (ctl !== RUN_O) $display("FAIL zero_reg got=%b exp=%b", ctl, RUN_O);
        else n_pass++;
        tick();
        n_total++;
        if (Stall_Cnt !== 16'(exp_sc)) $display("FAIL zero_cnt got=%0d exp=%0d", Stall_Cnt, exp_sc);
        else n_pass++;
        idle();
    endtask

    task automatic test_mdu();
        idle();
        ID_MduStart = 1'b1;
        #1;
        n_total++;
        if (ctl !== RUN_O) $display("FAIL mdu_accept got=%b exp=%b", ctl, RUN_O);
        else n_pass++;
        tick();
        ID_MduStart = 1'b0; ID_MduRead = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_total++;
            if (ctl !== STL_O || MduBusy !== 1'b1)
                $display("FAIL mdu_stall%0d ctl=%b busy=%b exp=%b/1", k, ctl, MduBusy, STL_O);
            else n_pass++;
            tick();
            exp_sc++;
        end
        #1;
        n_total++;
        if (ctl !== RUN_O || MduBusy !== 1'b0)
            $display("FAIL mdu_release ctl=%b busy=%b exp=%b/0", ctl, MduBusy, RUN_O);
        else n_pass++;
        n_total++;
        if (Stall_Cnt !== 16'(exp_sc)) $display("FAIL mdu_cnt got=%0d exp=%0d", Stall_Cnt, exp_sc);
        else n_pass++;
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        ID_MduStart = 1'b1;
        tick();
        EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        #1;
        n_total++;
        if (ctl !== STL_O) $display("FAIL b2b_dual got=%b exp=%b", ctl, STL_O);
        else n_pass++;
        tick();
        exp_sc++;
        EX_MemRead = 1'b0;
        n_total++;
        if (Stall_Cnt !== 16'(exp_sc)) $display("FAIL b2b_dual_cnt got=%0d exp=%0d", Stall_Cnt, exp_sc);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (ctl !== STL_O) $display("FAIL b2b_stall%0d got=%b exp=%b", k, ctl, STL_O);
            else n_pass++;
            tick();
            exp_sc++;
        end
        #1;
        n_total++;
        if (ctl !== RUN_O) $display("FAIL b2b_reaccept got=%b exp=%b", ctl, RUN_O);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (MduBusy !== 1'b1 || Stall_Cnt !== 16'(exp_sc))
            $display("FAIL b2b_reload busy=%b cnt=%0d exp=1/%0d", MduBusy, Stall_Cnt, exp_sc);
        else n_pass++;
        for (int k = 0; k < 4; k++) tick();
        n_total++;
        if (MduBusy !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", MduBusy);
        else n_pass++;
    endtask

    task automatic test_branch();
        idle();
        EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        EX_BranchTaken = 1'b1; ID_MduStart = 1'b1;
        #1;
        n_total++;
        if (ctl !== BR_O) $display("FAIL br_ctl got=%b exp=%b", ctl, BR_O);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (Stall_Cnt !== 16'(exp_sc) || MduBusy !== 1'b0)
            $display("FAIL br_after cnt=%0d busy=%b exp=%0d/0", Stall_Cnt, MduBusy, exp_sc);
        else n_pass++;
    endtask

    task automatic test_data_haz();
        logic [3:0] exp_ctl;
`ifdef PIPE_FWD_EN
        exp_ctl = RUN_O;
`else
        exp_ctl = STL_O;
`endif
        idle();
        MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd5; ID_Rt = 5'd5; ID_UsesRt = 1'b1;
        #1;
        n_total++;
        if (ctl !== exp_ctl) $display("FAIL raw_mem got=%b exp=%b", ctl, exp_ctl);
        else n_pass++;
        tick();
        if (exp_ctl == STL_O) exp_sc++;
        idle();
        EX_RegWrite = 1'b1; EX_WriteReg = 5'd6; ID_Rs = 5'd6;
        #1;
        n_total++;
        if (ctl !== exp_ctl) $display("FAIL raw_ex got=%b exp=%b", ctl, exp_ctl);
        else n_pass++;
        tick();
        if (exp_ctl == STL_O) exp_sc++;
        idle();
        MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd5; ID_Rs = 5'd1; ID_Rt = 5'd5;
        #1;
        n_total++;
        if (ctl !== RUN_O || Stall_Cnt !== 16'(exp_sc))
            $display("FAIL raw_none ctl=%b cnt=%0d exp=%b/%0d", ctl, Stall_Cnt, RUN_O, exp_sc);
        else n_pass++;
        idle();
    endtask

    task automatic test_reset_mid_mdu();
        idle();
        ID_MduStart = 1'b1;
        tick();
        ID_MduStart = 1'b0;
        tick();
        ID_MduRead = 1'b1;
        Rst = 1'b1;
        #1;
        n_total++;
        if (ctl !== RST_O || MduBusy !== 1'b0 || Stall_Cnt !== 16'd0)
            $display("FAIL rst_mid ctl=%b busy=%b cnt=%0d exp=%b/0/0", ctl, MduBusy, Stall_Cnt, RST_O);
        else n_pass++;
        tick();
        Rst = 1'b0;
        exp_sc = 0;
        #1;
        n_total++;
        if (ctl !== RUN_O || MduBusy !== 1'b0)
            $display("FAIL rst_mid_release ctl=%b busy=%b exp=%b/0", ctl, MduBusy, RUN_O);
        else n_pass++;
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_reg_zero();
        test_mdu();
        test_back_to_back();
        test_branch();
        test_data_haz();
        test_reset_mid_mdu();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
